sr04_echo_responder: RTL and testbench

Emulates the sensor side of the SR04 ultrasonic protocol for hardware-in-the-loop and self-test of the robot's sensor channels. It watches a trigger line, validates the trigger pulse width, waits a fixed burst delay, then drives an echo pulse whose width encodes a programmed distance, or the no-object timeout width. One instance sits on each sensor channel's trig/echo pins in place of a physical module. All timing is counted on the shared 1 MHz tick, so its encoding matches the distance decode used by the robot's sensor driver (echo µs / 64).

---
 rtl/sr04_echo_responder_if.sv | 19 +
 rtl/sr04_echo_responder.sv | 130 +++++++++++++
 tb/tb_sr04_echo_responder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/sr04_echo_responder_if.sv
// Trigger/echo pin bundle between an SR04 initiator and the emulated sensor side.
interface sr04_echo_responder_if;
  logic       trig_rx;
  logic [8:0] distance;
  logic       no_object;
  logic       echo_tx;
  logic       busy;
  logic       short_trig;

  modport master (
    output trig_rx, distance, no_object,
    input  echo_tx, busy, short_trig
  );

  modport slave (
    input  trig_rx, distance, no_object,
    output echo_tx, busy, short_trig
  );
endinterface

// File: rtl/sr04_echo_responder.sv
// SR04 sensor emulator: validates a trigger pulse, waits the burst delay, then
// returns an echo whose width in 1 MHz ticks encodes the programmed distance.
module sr04_echo_responder #(
  parameter int MIN_TRIG_US    = 10,
  parameter int BURST_DELAY_US = 200,
  parameter int US_PER_CM      = 64,
  parameter int TIMEOUT_US     = 38000,
  parameter int HOLDOFF_US     = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clock_1MHz,
  input  logic                clock_1MHz_prev,
  sr04_echo_responder_if.slave bus
);
  localparam logic [15:0] MIN_TRIG = 16'(MIN_TRIG_US);
  localparam logic [15:0] BURST    = 16'(BURST_DELAY_US);
  localparam logic [15:0] PER_CM   = 16'(US_PER_CM);
  localparam logic [15:0] TIMEOUT  = 16'(TIMEOUT_US);
  localparam logic [15:0] HOLDOFF  = 16'(HOLDOFF_US);

  typedef enum logic [2:0] {IDLE, TRIG, BURST_WAIT, ECHO, HOLD} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] width;
  logic        trig_s_p0, trig_s_p1, trig_prev_p2;
  logic        echo_q, busy_q, short_q;
  logic        tick, trig_rise, trig_fall;
  logic [15:0] cnt_inc;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Distance 0 is clamped to 1 cm; 511 cm * 64 still fits in 16 bits.
  function automatic logic [15:0] echo_width(input logic [8:0] d, input logic no_obj);
    logic [15:0] d_cm;
    d_cm = (d == 9'd0) ? 16'd1 : {7'd0, d};
    return no_obj ? TIMEOUT : d_cm * PER_CM;
  endfunction

  assign tick      = clock_1MHz & ~clock_1MHz_prev;
  assign trig_rise = trig_s_p1 & ~trig_prev_p2;
  assign trig_fall = ~trig_s_p1 & trig_prev_p2;
  assign cnt_inc   = tick ? sat_inc(cnt) : cnt;

  assign bus.echo_tx    = echo_q;
  assign bus.busy       = busy_q;
  assign bus.short_trig = short_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      width        <= '0;
      echo_q       <= 1'b0;
      busy_q       <= 1'b0;
      short_q      <= 1'b0;
      trig_s_p0    <= 1'b0;
      trig_s_p1    <= 1'b0;
      trig_prev_p2 <= 1'b0;
    end else begin
      // p0/p1: trigger synchronizer, p2: previous value for edge detection
      trig_s_p0    <= bus.trig_rx;
      trig_s_p1    <= trig_s_p0;
      trig_prev_p2 <= trig_s_p1;
      short_q      <= 1'b0;

      case (state)
        IDLE: begin
          if (trig_rise) begin
            state  <= TRIG;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        TRIG: begin
          // A tick landing on the falling-edge cycle still counts toward the width.
          if (trig_fall) begin
            cnt <= '0;
            if (cnt_inc >= MIN_TRIG) begin
              width <= echo_width(bus.distance, bus.no_object);
              state <= BURST_WAIT;
            end else begin
              short_q <= 1'b1;
              busy_q  <= 1'b0;
              state   <= IDLE;
            end
          end else if (trig_s_p1) begin
            cnt <= cnt_inc;
          end
        end
        BURST_WAIT: begin
          if (cnt_inc >= BURST) begin
            cnt    <= '0;
            echo_q <= 1'b1;
            state  <= ECHO;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ECHO: begin
          if (cnt_inc >= width) begin
            cnt    <= '0;
            echo_q <= 1'b0;
            state  <= HOLD;
          end else begin
            cnt <= cnt_inc;
          end
        end
        HOLD: begin
          if (cnt_inc >= HOLDOFF) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          cnt    <= '0;
          echo_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sr04_echo_responder.sv
// Bench for sr04_echo_responder: table vectors, hand-written corner sequences and
// randomized transactions checked against a distance-to-width reference model.
module tb_sr04_echo_responder;
  localparam int MIN_TRIG = 10;
  localparam int BURST    = 40;
  localparam int PER_CM   = 64;
  localparam int TIMEOUT  = 300;
  localparam int HOLDOFF  = 30;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clock_1MHz = 1'b0;
  logic clock_1MHz_prev = 1'b0;
  int   checks = 0;
  int   failures = 0;

  sr04_echo_responder_if bus ();

  sr04_echo_responder #(
    .MIN_TRIG_US(MIN_TRIG),
    .BURST_DELAY_US(BURST),
    .US_PER_CM(PER_CM),
    .TIMEOUT_US(TIMEOUT),
    .HOLDOFF_US(HOLDOFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clock_1MHz(clock_1MHz),
    .clock_1MHz_prev(clock_1MHz_prev),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Fastest legal tick: the level toggles every clk, giving one tick per 2 clk.
  initial begin
    forever begin
      @(negedge clk);
      clock_1MHz_prev = clock_1MHz;
      clock_1MHz      = ~clock_1MHz;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int n;
    int d;
    bit nobj;
    bit exp_acc;
    int exp_w;
  } vec_t;

  function automatic int model_width(input int d, input bit nobj);
    if (nobj) return TIMEOUT;
    return ((d < 1) ? 1 : d) * PER_CM;
  endfunction

  task automatic check(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // mode bit0: change distance to 200 during the burst; bit1: extra trigger mid-echo.
  task automatic run_txn(input int n, input int d, input bit nobj, input int mode,
                         input bit exp_acc, input int exp_w);
    int c;
    int shorts;
    bit seen;
    bus.distance  = 9'(d);
    bus.no_object = nobj;
    bus.trig_rx   = 1'b1;
    repeat (2 * n) @(negedge clk);
    check("busy_in_trig", int'(bus.busy), 1, 1);
    bus.trig_rx = 1'b0;
    if (!exp_acc) begin
      shorts = 0;
      seen   = 1'b0;
      for (int i = 1; i <= 8; i++) begin
        @(negedge clk);
        shorts += int'(bus.short_trig);
        if (bus.echo_tx) seen = 1'b1;
        if (i == 3) check("reject_busy_low", int'(bus.busy), 0, 0);
      end
      check("short_trig_pulses", shorts, 1, 1);
      check("reject_no_echo", int'(seen), 0, 0);
      return;
    end
    c = 0;
    shorts = 0;
    while (!bus.echo_tx && c < 2 * BURST + 20) begin
      @(negedge clk);
      c++;
      shorts += int'(bus.short_trig);
      if (mode[0] && c == 20) bus.distance = 9'd200;
    end
    check("burst_delay_clk", c, 2 * BURST - 2, 2 * BURST + 4);
    c = 0;
    while (bus.echo_tx && c < 2 * exp_w + 20) begin
      if (mode[1]) bus.trig_rx = (c >= 100 && c < 124);
      @(negedge clk);
      c++;
      shorts += int'(bus.short_trig);
    end
    bus.trig_rx = 1'b0;
    check("echo_high_clk", c, 2 * exp_w - 2, 2 * exp_w + 2);
    c = 0;
    while (bus.busy && c < 2 * HOLDOFF + 20) begin
      @(negedge clk);
      c++;
    end
    check("holdoff_clk", c, 2 * HOLDOFF - 2, 2 * HOLDOFF + 2);
    check("accept_no_short", shorts, 0, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.echo_tx || bus.busy) seen = 1'b1;
    end
    check("quiet_after_txn", int'(seen), 0, 0);
  endtask

  initial begin
    vec_t vecs[7];
    int   c;
    int   n, d;
    bit   nobj;

    vecs[0] = '{5,  20,  1'b0, 1'b0, 0};
    vecs[1] = '{9,  7,   1'b0, 1'b0, 0};
    vecs[2] = '{10, 3,   1'b0, 1'b1, 192};
    vecs[3] = '{12, 40,  1'b1, 1'b1, 300};
    vecs[4] = '{14, 0,   1'b0, 1'b1, 64};
    vecs[5] = '{11, 1,   1'b0, 1'b1, 64};
    vecs[6] = '{12, 511, 1'b0, 1'b1, 32704};

    bus.trig_rx   = 1'b0;
    bus.distance  = 9'd0;
    bus.no_object = 1'b0;
    reset         = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_echo", int'(bus.echo_tx), 0, 0);
    check("reset_busy", int'(bus.busy), 0, 0);
    check("reset_short", int'(bus.short_trig), 0, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_txn(vecs[i].n, vecs[i].d, vecs[i].nobj, 0, vecs[i].exp_acc, vecs[i].exp_w);

    // Distance change mid-burst plus a second trigger mid-echo: one 50 cm echo.
    run_txn(12, 50, 1'b0, 3, 1'b1, 3200);

    // Reset pulse in the middle of an echo.
    bus.distance  = 9'd50;
    bus.no_object = 1'b0;
    bus.trig_rx   = 1'b1;
    repeat (24) @(negedge clk);
    bus.trig_rx = 1'b0;
    c = 0;
    while (!bus.echo_tx && c < 2 * BURST + 20) begin
      @(negedge clk);
      c++;
    end
    check("rst_seq_echo_rise", int'(bus.echo_tx), 1, 1);
    repeat (600) @(negedge clk);
    check("rst_seq_echo_mid", int'(bus.echo_tx), 1, 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rst_mid_echo_low", int'(bus.echo_tx), 0, 0);
    check("rst_mid_busy_low", int'(bus.busy), 0, 0);
    repeat (10) @(negedge clk);
    check("rst_echo_stays_low", int'(bus.echo_tx), 0, 0);
    run_txn(10, 2, 1'b0, 0, 1'b1, 128);

    for (int t = 0; t < 6; t++) begin
      n    = int'($urandom_range(3, 16));
      d    = int'($urandom_range(0, 3));
      nobj = ($urandom_range(0, 4) == 0);
      run_txn(n, d, nobj, 0, n >= MIN_TRIG, model_width(d, nobj));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
